// File: rtl/lut_neuron_loader.sv
// 256x1 truth-table neuron: 32 byte beats load the table, then one-cycle lookups.
// cfg_ready is high only while loading; lookups never stall and are dropped unless armed.
module lut_neuron_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_data,
  input  logic       cfg_last,
  input  logic       cfg_clear,
  output logic       cfg_done,
  output logic       cfg_err,
  input  logic       in_valid,
  input  logic [7:0] M0,
  output logic       out_valid,
  output logic       M1
);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_ERROR = 2'd2;

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic [4:0]   r_cnt;
  logic [255:0] r_table;
  logic         w_accept;
  logic         w_lookup;

  // A clear in the same cycle as a beat wins, so the beat is not taken.
  assign w_accept = cfg_valid & cfg_ready & ~cfg_clear;
  assign w_lookup = in_valid & (r_state == S_ARMED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          if (r_cnt == 5'd31) begin
            w_state_nxt = cfg_last ? S_ARMED : S_ERROR;
          end else if (cfg_last) begin
            w_state_nxt = S_ERROR;
          end
        end
      end
      S_ARMED: w_state_nxt = S_ARMED;
      S_ERROR: w_state_nxt = S_ERROR;
      default: w_state_nxt = S_ERROR;
    endcase
    if (cfg_clear) begin
      w_state_nxt = S_LOAD;
    end
  end

  always_comb begin
    cfg_ready = 1'b0;
    cfg_done  = 1'b0;
    cfg_err   = 1'b0;
    case (r_state)
      S_LOAD:  cfg_ready = 1'b1;
      S_ARMED: cfg_done  = 1'b1;
      default: cfg_err   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 5'd0;
      r_table   <= '0;
      out_valid <= 1'b0;
      M1        <= 1'b0;
    end else begin
      if (cfg_clear) begin
        r_cnt <= 5'd0;
      end else if (w_accept) begin
        r_cnt <= (w_state_nxt == S_LOAD) ? r_cnt + 5'd1 : 5'd0;
      end
      if (w_accept) begin
        r_table[{r_cnt, 3'b000} +: 8] <= cfg_data;
      end
      out_valid <= w_lookup;
      if (w_lookup) begin
        M1 <= r_table[M0];
      end
    end
  end

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Directed bench for lut_neuron_loader: load, lookup, malformed loads, clear and reset.
module tb_lut_neuron_loader;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       cfg_last;
  logic       cfg_clear;
  logic       cfg_done;
  logic       cfg_err;
  logic       in_valid;
  logic [7:0] M0;
  logic       out_valid;
  logic       M1;

  int n_cmp;
  int n_bad;

  lut_neuron_loader dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .cfg_clear (cfg_clear),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .M0        (M0),
    .out_valid (out_valid),
    .M1        (M1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    tick();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic clear_pulse();
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
  endtask

  task automatic lookup(input logic [7:0] a);
    in_valid = 1'b1;
    M0       = a;
    tick();
    in_valid = 1'b0;
  endtask

  logic [7:0] bt;
  logic       eb;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; cfg_valid = 1'b0; cfg_data = 8'h00; cfg_last = 1'b0;
    cfg_clear = 1'b0; in_valid = 1'b0; M0 = 8'h00;
    tick(); tick();
    chk("rst_ready", cfg_ready, 1);
    chk("rst_done",  cfg_done,  0);
    chk("rst_err",   cfg_err,   0);
    chk("rst_ovld",  out_valid, 0);
    chk("rst_m1",    M1,        0);

    // full load, first beat on the first edge after reset release
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      beat(8'hA5 ^ 8'(k), k == 31);
      if (k == 30) begin
        chk("load_done_b30",  cfg_done,  0);
        chk("load_ready_b30", cfg_ready, 1);
      end
    end
    chk("load_done",  cfg_done,  1);
    chk("load_ready", cfg_ready, 0);
    chk("load_err",   cfg_err,   0);

    lookup(8'h00); chk("lk00_vld", out_valid, 1); chk("lk00", M1, 1);
    lookup(8'h01); chk("lk01_vld", out_valid, 1); chk("lk01", M1, 0);
    lookup(8'hF9); chk("lkF9_vld", out_valid, 1); chk("lkF9", M1, 1);

    // all 256 addresses back to back
    in_valid = 1'b1;
    for (int a = 0; a < 256; a++) begin
      M0 = 8'(a);
      tick();
      bt = 8'hA5 ^ 8'(a >> 3);
      eb = bt[a % 8];
      chk("sweep_vld", out_valid, 1);
      chk("sweep_m1",  M1,        eb);
    end
    in_valid = 1'b0;
    tick();
    chk("idle_vld", out_valid, 0);
    chk("idle_m1_hold", M1, 1);  // address 0xFF: bit 7 of 0xBA

    // lookup sampled together with clear completes with the old table
    in_valid = 1'b1; M0 = 8'h01; cfg_clear = 1'b1;
    tick();
    in_valid = 1'b0; cfg_clear = 1'b0;
    chk("clr_lk_vld",  out_valid, 1);
    chk("clr_lk_m1",   M1,        0);
    chk("clr_ready",   cfg_ready, 1);
    chk("clr_done",    cfg_done,  0);

    // early last on beat 5
    for (int k = 0; k < 6; k++) beat(8'hFF, k == 5);
    chk("early_err",   cfg_err,   1);
    chk("early_ready", cfg_ready, 0);
    chk("early_done",  cfg_done,  0);
    lookup(8'h00);
    chk("early_lk_vld", out_valid, 0);
    clear_pulse();
    chk("early_clr_err",   cfg_err,   0);
    chk("early_clr_ready", cfg_ready, 1);

    // clear collides with beat 10, then a clean reload
    for (int k = 0; k < 10; k++) beat(8'h00, 1'b0);
    cfg_valid = 1'b1; cfg_data = 8'h55; cfg_clear = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_clear = 1'b0;
    chk("coll_ready", cfg_ready, 1);
    chk("coll_err",   cfg_err,   0);
    for (int k = 0; k < 32; k++) beat(8'h3C ^ 8'(k), k == 31);
    chk("reload_done", cfg_done, 1);
    chk("reload_err",  cfg_err,  0);
    lookup(8'h07); chk("rl07", M1, 0);
    lookup(8'h52); chk("rl52_vld", out_valid, 1); chk("rl52", M1, 1);

    // missing last
    clear_pulse();
    for (int k = 0; k < 32; k++) begin
      beat(8'h0F, 1'b0);
      if (k == 30) chk("miss_err_b30", cfg_err, 0);
    end
    chk("miss_err",  cfg_err,  1);
    chk("miss_done", cfg_done, 0);

    // asynchronous reset in the middle of beat 20 with a lookup pending
    clear_pulse();
    for (int k = 0; k < 20; k++) beat(8'hFF, 1'b0);
    cfg_valid = 1'b1; cfg_data = 8'hFF; in_valid = 1'b1; M0 = 8'h52;
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", cfg_ready, 1);
    chk("arst_done",  cfg_done,  0);
    chk("arst_err",   cfg_err,   0);
    chk("arst_ovld",  out_valid, 0);
    chk("arst_m1",    M1,        0);
    cfg_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_vld",  out_valid, 0);
      chk("post_rst_m1",   M1,        0);
      chk("post_rst_done", cfg_done,  0);
    end
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
